// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the MEM stage and a req/gnt/rvalid data port.
// Misaligned halfword/word accesses become two word transactions when SPLIT_EN=1.
module lsu_ctrl #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ0  = 3'd1;
    localparam logic [2:0] ST_WAIT0 = 3'd2;
    localparam logic [2:0] ST_REQ1  = 3'd3;
    localparam logic [2:0] ST_WAIT1 = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]  state_r;
    logic [1:0]  off_r;
    logic        we_r;
    logic [31:0] wdata_r;
    logic [2:0]  funct3_r;
    logic [31:0] lo_r;
    logic        req_split_s;
    logic        cur_split_s;

    // Byte enables of the size pattern shifted to the offset; hi selects the spill into the next word.
    function automatic logic [3:0] be_part(input logic [2:0] f3, input logic [1:0] off, input logic hi);
        logic [7:0] full;
        case (f3[1:0])
            2'b00:   full = 8'b0000_0001;
            2'b01:   full = 8'b0000_0011;
            default: full = 8'b0000_1111;
        endcase
        full = full << off;
        be_part = hi ? full[7:4] : full[3:0];
    endfunction

    function automatic logic [31:0] wd_part(input logic [31:0] wd, input logic [1:0] off, input logic hi);
        logic [63:0] full;
        full = {32'd0, wd} << {off, 3'b000};
        wd_part = hi ? full[63:32] : full[31:0];
    endfunction

    function automatic logic [31:0] load_merge(input logic [63:0] hilo, input logic [1:0] off,
                                               input logic [2:0] f3);
        logic [63:0] sh;
        logic [31:0] raw;
        sh  = hilo >> {off, 3'b000};
        raw = sh[31:0];
        case (f3)
            3'b000:  load_merge = {{24{raw[7]}}, raw[7:0]};
            3'b001:  load_merge = {{16{raw[15]}}, raw[15:0]};
            3'b100:  load_merge = {24'd0, raw[7:0]};
            3'b101:  load_merge = {16'd0, raw[15:0]};
            default: load_merge = raw;
        endcase
    endfunction

    assign req_ready = (state_r == ST_IDLE);
    assign stall     = ((state_r != ST_IDLE) && (state_r != ST_DONE)) ||
                       ((state_r == ST_IDLE) && req_valid);

    // An access is split exactly when its byte lanes spill past lane 3.
    always_comb begin
        req_split_s = |be_part(req_funct3, req_addr[1:0], 1'b1);
        cur_split_s = |be_part(funct3_r, off_r, 1'b1);
    end

    // Sequencer state, captured request and registered memory/response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            off_r        <= 2'd0;
            we_r         <= 1'b0;
            wdata_r      <= 32'd0;
            funct3_r     <= 3'd0;
            lo_r         <= 32'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_be       <= 4'd0;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    resp_valid   <= 1'b0;
                    misalign_err <= 1'b0;
                    if (req_valid) begin
                        off_r    <= req_addr[1:0];
                        we_r     <= req_we;
                        wdata_r  <= req_wdata;
                        funct3_r <= req_funct3;
                        if (req_split_s && !SPLIT_EN) begin
                            state_r      <= ST_DONE;
                            resp_valid   <= 1'b1;
                            misalign_err <= 1'b1;
                            resp_rdata   <= 32'd0;
                        end else begin
                            state_r   <= ST_REQ0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= be_part(req_funct3, req_addr[1:0], 1'b0);
                            mem_wdata <= wd_part(req_wdata, req_addr[1:0], 1'b0);
                        end
                    end
                end
                ST_REQ0: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state_r <= ST_WAIT0;
                    end
                end
                ST_WAIT0: begin
                    if (mem_rvalid) begin
                        lo_r <= mem_rdata;
                        if (cur_split_s) begin
                            state_r   <= ST_REQ1;
                            mem_req   <= 1'b1;
                            mem_addr  <= mem_addr + 32'd4;
                            mem_be    <= be_part(funct3_r, off_r, 1'b1);
                            mem_wdata <= wd_part(wdata_r, off_r, 1'b1);
                        end else begin
                            state_r    <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_rdata <= we_r ? 32'd0 : load_merge({32'd0, mem_rdata}, off_r, funct3_r);
                        end
                    end
                end
                ST_REQ1: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state_r <= ST_WAIT1;
                    end
                end
                ST_WAIT1: begin
                    if (mem_rvalid) begin
                        state_r    <= ST_DONE;
                        resp_valid <= 1'b1;
                        resp_rdata <= we_r ? 32'd0 : load_merge({mem_rdata, lo_r}, off_r, funct3_r);
                    end
                end
                ST_DONE: begin
                    resp_valid   <= 1'b0;
                    misalign_err <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl: a byte-level memory model predicts transactions and load data,
// a single negedge process checks the DUT and plays the memory side.
module tb_lsu_ctrl;
    typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } txn_t;
    typedef struct { logic [31:0] rdata; logic err; } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic        req_ready, stall, resp_valid, misalign_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    logic        req_valid2 = 1'b0;
    logic [31:0] req_addr2 = 32'd0;
    logic [2:0]  req_funct3_2 = 3'd0;
    logic        req_ready2, stall2, resp_valid2, misalign_err2;
    logic [31:0] resp_rdata2;
    logic        mem_req2, mem_we2;
    logic [31:0] mem_addr2, mem_wdata2;
    logic [3:0]  mem_be2;
    logic        mem_gnt2 = 1'b0, mem_rvalid2 = 1'b0;
    logic [31:0] mem_rdata2 = 32'd0;

    int n_vec = 0, n_miss = 0, cyc = 0;
    int n_resp = 0, n_txn = 0, resp_cyc = 0;
    logic [31:0] last_rdata;
    txn_t  exp_txn[$], obs_q[$];
    resp_t exp_resp[$];
    logic [31:0] dmem[logic [31:0]];
    logic [31:0] rmem[logic [31:0]];
    bit fast = 1'b0, noise = 1'b0, inflight = 1'b0, prev_req = 1'b0, pend = 1'b0;
    int hold = 0, rvd = 0, cnt = 0;
    txn_t snap, cur;

    lsu_ctrl #(.SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_funct3(req_funct3), .req_ready(req_ready), .stall(stall),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misalign_err(misalign_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

    lsu_ctrl #(.SPLIT_EN(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_we(1'b0), .req_addr(req_addr2),
        .req_wdata(32'd0), .req_funct3(req_funct3_2), .req_ready(req_ready2), .stall(stall2),
        .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .misalign_err(misalign_err2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_be(mem_be2), .mem_gnt(mem_gnt2), .mem_rvalid(mem_rvalid2), .mem_rdata(mem_rdata2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
    endfunction

    function automatic logic [31:0] dget(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] rget(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Reference: walk the accessed bytes one by one and group them into word transactions.
    task automatic model_push(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
        int n, nw, k, lane;
        logic [31:0] w0, ba, w, val;
        txn_t t[2];
        n  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        w0 = {a[31:2], 2'b00};
        nw = 1;
        val = 32'd0;
        for (int j = 0; j < 2; j++) begin
            t[j].addr = w0 + 32'(4 * j); t[j].be = 4'd0; t[j].we = we; t[j].wdata = 32'd0;
        end
        for (int i = 0; i < n; i++) begin
            ba   = a + 32'(i);
            w    = {ba[31:2], 2'b00};
            k    = (w == w0) ? 0 : 1;
            lane = int'(ba[1:0]);
            if (k == 1) nw = 2;
            t[k].be[lane] = 1'b1;
            t[k].wdata[lane*8 +: 8] = wd[i*8 +: 8];
            if (we) begin
                logic [31:0] rw;
                rw = rget(w);
                rw[lane*8 +: 8] = wd[i*8 +: 8];
                rmem[w] = rw;
            end else begin
                logic [31:0] rw;
                rw = rget(w);
                val[i*8 +: 8] = rw[lane*8 +: 8];
            end
        end
        if (!we && f3 == 3'b000) val = {{24{val[7]}}, val[7:0]};
        if (!we && f3 == 3'b001) val = {{16{val[15]}}, val[15:0]};
        for (int j = 0; j < nw; j++) exp_txn.push_back(t[j]);
        exp_resp.push_back('{rdata: val, err: 1'b0});
    endtask

    // Compare process and memory responder, both on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pend = 1'b0; inflight = 1'b0; prev_req = 1'b0;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
        end else begin
            check("req_ready", {31'd0, req_ready}, {31'd0, !inflight});
            check("stall", {31'd0, stall}, {31'd0, inflight ? !resp_valid : req_valid});
            if (resp_valid) begin
                resp_t e;
                n_resp++; resp_cyc = cyc; last_rdata = resp_rdata;
                if (exp_resp.size() == 0) begin
                    check("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_resp.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("misalign_err", {31'd0, misalign_err}, {31'd0, e.err});
                end
                check("txn_left", exp_txn.size(), 32'd0);
            end
            cur = '{addr: mem_addr, be: mem_be, we: mem_we, wdata: mem_wdata};
            if (mem_req) begin
                if (!prev_req) snap = cur;
                else check("req_stable", {cur.addr ^ snap.addr} | {27'd0, cur.we ^ snap.we, cur.be ^ snap.be} | (cur.wdata ^ snap.wdata), 32'd0);
            end
            prev_req = mem_req;
            if (resp_valid) inflight = 1'b0;
            else if (req_valid && req_ready) inflight = 1'b1;

            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (pend) begin
                if (cnt <= 1) begin
                    logic [31:0] w;
                    mem_rvalid = 1'b1;
                    mem_rdata  = dget(snap.addr);
                    if (snap.we) begin
                        w = dget(snap.addr);
                        w = (w & ~be_mask(snap.be)) | (snap.wdata & be_mask(snap.be));
                        dmem[snap.addr] = w;
                    end
                    pend = 1'b0;
                end else cnt--;
            end else if (mem_req) begin
                if (hold > 0) hold--;
                else if (fast || $urandom_range(0, 2) != 0) begin
                    txn_t e;
                    mem_gnt = 1'b1; pend = 1'b1; n_txn++;
                    cnt = (rvd > 0) ? rvd : (fast ? 1 : int'($urandom_range(1, 3)));
                    obs_q.push_back(cur);
                    if (exp_txn.size() == 0) check("txn_unexpected", 32'd1, 32'd0);
                    else begin
                        e = exp_txn.pop_front();
                        check("txn_addr", cur.addr, e.addr);
                        check("txn_be", {28'd0, cur.be}, {28'd0, e.be});
                        check("txn_we", {31'd0, cur.we}, {31'd0, e.we});
                        check("txn_wdata", cur.wdata & be_mask(e.be), e.wdata);
                    end
                end
            end else if (noise) begin
                mem_gnt    = ($urandom_range(0, 3) == 0);
                mem_rvalid = ($urandom_range(0, 3) == 0);
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input int lat);
        int r0, t0, k;
        model_push(we, a, wd, f3);
        obs_q.delete();
        @(posedge clk); #2;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
        t0 = cyc; r0 = n_resp;
        for (k = 0; k < 300 && n_resp == r0; k++) @(posedge clk);
        #2;
        req_valid = 1'b0;
        check("resp_seen", {31'd0, n_resp != r0}, 32'd1);
        if (lat > 0) check("latency", resp_cyc - t0, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, k, r0, nres, nerr, rc;
        bit saw_req;
        logic [31:0] rd2;
        #3;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_oth", {27'd0, mem_we, mem_be} | mem_wdata, 32'd0);
        check("rst_resp", {30'd0, resp_valid, misalign_err} | resp_rdata, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        #20 rst_n = 1'b1;

        dmem[32'h1000] = 32'h80AA_55CC; rmem[32'h1000] = 32'h80AA_55CC;
        dmem[32'h3000] = 32'h4433_2211; rmem[32'h3000] = 32'h4433_2211;
        dmem[32'h3004] = 32'h8877_6655; rmem[32'h3004] = 32'h8877_6655;
        fast = 1'b1;

        do_req(1'b0, 32'h0000_1003, 32'd0, 3'b000, 3);
        check("lb_rdata", last_rdata, 32'hFFFF_FF80);
        check("lb_be", {28'd0, obs_q[0].be}, 32'h8);
        check("lb_ntxn", obs_q.size(), 32'd1);
        do_req(1'b0, 32'h0000_1003, 32'd0, 3'b100, 3);
        check("lbu_rdata", last_rdata, 32'h0000_0080);

        do_req(1'b1, 32'h0000_2002, 32'h0000_BEEF, 3'b001, 3);
        check("sh_addr", obs_q[0].addr, 32'h0000_2000);
        check("sh_be", {28'd0, obs_q[0].be}, 32'hC);
        check("sh_wdata", obs_q[0].wdata, 32'hBEEF_0000);
        check("sh_rdata", last_rdata, 32'd0);

        do_req(1'b0, 32'h0000_3001, 32'd0, 3'b010, 5);
        check("lw_rdata", last_rdata, 32'h5544_3322);
        check("lw_be0", {28'd0, obs_q[0].be}, 32'hE);
        check("lw_be1", {28'd0, obs_q[1].be}, 32'h1);

        do_req(1'b1, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 3'b010, 5);
        check("sw_addr0", obs_q[0].addr, 32'hFFFF_FFFC);
        check("sw_be0", {28'd0, obs_q[0].be}, 32'hC);
        check("sw_wd0", obs_q[0].wdata, 32'hC3D4_0000);
        check("sw_addr1", obs_q[1].addr, 32'h0000_0000);
        check("sw_be1", {28'd0, obs_q[1].be}, 32'h3);
        check("sw_wd1", obs_q[1].wdata, 32'h0000_A1B2);

        hold = 3;
        do_req(1'b0, 32'h0000_3000, 32'd0, 3'b010, 6);
        check("hold_rdata", last_rdata, 32'h4433_2211);

        rvd = 20;
        model_push(1'b0, 32'h0000_5000, 32'd0, 3'b010);
        r0 = n_txn;
        @(posedge clk); #2;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_5000; req_funct3 = 3'b010;
        for (k = 0; k < 50 && n_txn == r0; k++) @(posedge clk);
        check("rst_txn_seen", {31'd0, n_txn != r0}, 32'd1);
        @(posedge clk); #2;
        req_valid = 1'b0; rst_n = 1'b0;
        #1;
        check("abort_mem_req", {31'd0, mem_req}, 32'd0);
        check("abort_resp", {31'd0, resp_valid}, 32'd0);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        exp_txn.delete(); exp_resp.delete();
        r0 = n_resp;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1; rvd = 0;
        repeat (4) @(posedge clk);
        #2;
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check("post_rst_noresp", n_resp, r0);

        fast = 1'b0; noise = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic we;
            logic [31:0] a;
            logic [2:0] f3;
            we = $urandom_range(0, 1) == 1;
            a  = 32'h0000_0100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC + $urandom_range(0, 3);
            f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            do_req(we, a, $urandom, f3, 0);
        end
        noise = 1'b0;

        @(posedge clk); #2;
        req_valid2 = 1'b1; req_addr2 = 32'h0000_4003; req_funct3_2 = 3'b001;
        t0 = cyc; saw_req = 1'b0; nres = 0; nerr = 0; rc = -1; rd2 = 32'hDEAD_BEEF;
        for (k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_req2) saw_req = 1'b1;
            if (misalign_err2) nerr++;
            if (resp_valid2) begin
                nres++;
                if (rc < 0) begin rc = cyc; rd2 = resp_rdata2; end
                req_valid2 = 1'b0;
            end
        end
        check("mis_no_req", {31'd0, saw_req}, 32'd0);
        check("mis_resp_cnt", nres, 32'd1);
        check("mis_err_cnt", nerr, 32'd1);
        check("mis_resp_cyc", rc - t0, 32'd1);
        check("mis_rdata", rd2, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
